note_chart_sequencer: RTL and testbench

//  Song-chart player; the producer side of the falling-note display interface.

---
 rtl/note_chart_sequencer.sv | 157 +++++++++++++++
 tb/tb_note_chart_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_chart_sequencer.sv
// Song-chart player: walks a registered chart ROM and drives the wren/key_address stream, paced by the 0.02 s tick.
// Optional LOOP_EN: at end of song, restart from address 0 instead of parking in DONE.
module note_chart_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int NOTE_TICKS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              wren,
    output logic [1:0]        key_address,
    output logic              busy,
    output logic              song_done,
    output logic [9:0]        note_count,
    output logic [2:0]        debug_state
);

    localparam int HOLD_W = $clog2(NOTE_TICKS + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [13:0]       dur_cnt, dur_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [ADDR_W-1:0] rom_addr_next;
    logic              wren_next;
    logic [1:0]        key_next;
    logic              song_done_next;
    logic [9:0]        note_count_next;
    logic              end_song;

    logic [1:0]  entry_code;
    logic [13:0] entry_dur;

    assign entry_code  = rom_data[15:14];
    assign entry_dur   = rom_data[13:0];
    assign busy        = (state == S_FETCH) || (state == S_LOAD) || (state == S_PLAY);
    assign debug_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            wren        <= 1'b1;
            key_address <= 2'b00;
            song_done   <= 1'b0;
            note_count  <= '0;
            dur_cnt     <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_next;
            rom_addr    <= rom_addr_next;
            wren        <= wren_next;
            key_address <= key_next;
            song_done   <= song_done_next;
            note_count  <= note_count_next;
            dur_cnt     <= dur_next;
            hold_cnt    <= hold_next;
        end
    end

    always_comb begin
        state_next      = state;
        rom_addr_next   = rom_addr;
        wren_next       = wren;
        key_next        = key_address;
        song_done_next  = 1'b0;
        note_count_next = note_count;
        dur_next        = dur_cnt;
        hold_next       = hold_cnt;
        end_song        = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                // A start pulse always wins over a coincident tick; nothing here consumes ticks.
                if (start) begin
                    state_next      = S_FETCH;
                    rom_addr_next   = '0;
                    note_count_next = '0;
                    wren_next       = 1'b0;
                    key_next        = 2'b00;
                end
            end

            S_FETCH: begin
                state_next = S_LOAD;
            end

            S_LOAD: begin
                if (entry_code == 2'b00 && entry_dur == 14'd0) begin
                    end_song = 1'b1;
                end else if (entry_code != 2'b00) begin
                    key_next  = entry_code;
                    hold_next = HOLD_W'(NOTE_TICKS);
                    dur_next  = (entry_dur == 14'd0) ? 14'd1 : entry_dur;
                    if (note_count != 10'd1023) begin
                        note_count_next = note_count + 10'd1;
                    end
                    state_next = S_PLAY;
                end else begin
                    key_next   = 2'b00;
                    hold_next  = '0;
                    dur_next   = entry_dur;
                    state_next = S_PLAY;
                end
            end

            S_PLAY: begin
                if (tick) begin
                    dur_next = dur_cnt - 14'd1;
                    if (hold_cnt != '0) begin
                        hold_next = hold_cnt - HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(1)) begin
                            key_next = 2'b00;
                        end
                    end
                    // dur_cnt is never 0 in PLAY, so 1 means this tick ends the entry.
                    if (dur_cnt == 14'd1) begin
                        key_next = 2'b00;
                        if (rom_addr == {ADDR_W{1'b1}}) begin
                            end_song = 1'b1;
                        end else begin
                            rom_addr_next = rom_addr + ADDR_W'(1);
                            state_next    = S_FETCH;
                        end
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (end_song) begin
            song_done_next = 1'b1;
            key_next       = 2'b00;
`ifdef LOOP_EN
            rom_addr_next  = '0;
            state_next     = S_FETCH;
`else
            state_next     = S_DONE;
`endif
        end
    end

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Bench for note_chart_sequencer: directed and random charts played against a per-tick timeline model.
module tb_note_chart_sequencer;

    localparam int ADDR_W     = 8;
    localparam int NOTE_TICKS = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              tick;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              wren;
    logic [1:0]        key_address;
    logic              busy;
    logic              song_done;
    logic [9:0]        note_count;
    logic [2:0]        debug_state;

    note_chart_sequencer #(.ADDR_W(ADDR_W), .NOTE_TICKS(NOTE_TICKS)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .tick        (tick),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .wren        (wren),
        .key_address (key_address),
        .busy        (busy),
        .song_done   (song_done),
        .note_count  (note_count),
        .debug_state (debug_state)
    );

    // clock / chart ROM / song_done monitor
    always #5 clock = ~clock;

    logic [15:0] rom [0:DEPTH-1];
    always @(posedge clock) rom_data <= rom[rom_addr];

    int done_cnt = 0;
    always @(negedge clock) if (song_done) done_cnt++;

    // scoreboard
    int checks   = 0;
    int failures = 0;
    logic [1:0]        exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                exp_notes;
    bit                exp_marker;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // chart helpers
    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
    endtask

    task automatic put(input int idx, input int code, input int dur);
        logic [1:0]  c;
        logic [13:0] d;
        c = code[1:0];
        d = dur[13:0];
        rom[idx] = {c, d};
    endtask

    // Expected key per tick slot: a note shows its lane for its first NOTE_TICKS ticks.
    task automatic build_model();
        int a;
        int code;
        int dur;
        int len;
        exp_q.delete();
        exp_addr_q.delete();
        exp_notes  = 0;
        exp_marker = 0;
        a = 0;
        forever begin
            code = int'(rom[a][15:14]);
            dur  = int'(rom[a][13:0]);
            if (code == 0 && dur == 0) begin
                exp_marker = 1;
                break;
            end
            len = (code != 0 && dur == 0) ? 1 : dur;
            for (int k = 0; k < len; k++) begin
                exp_q.push_back((code != 0 && k < NOTE_TICKS) ? code[1:0] : 2'b00);
                exp_addr_q.push_back(a[ADDR_W-1:0]);
            end
            if (code != 0) exp_notes++;
            if (a == DEPTH - 1) break;
            a++;
        end
        if (exp_notes > 1023) exp_notes = 1023;
    endtask

    // drivers
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_wren", wren, 1);
        check_eq("rst_key", key_address, 0);
        check_eq("rst_addr", rom_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_notes", note_count, 0);
        check_eq("rst_done", song_done, 0);
        reset = 1'b0;
    endtask

    task automatic run_song(input string name, input int abort_at, input bit mid_start, input bit start_tick);
        int base;
        int n;
        int gap;
        int k;
        logic [1:0]        ek;
        logic [ADDR_W-1:0] ea;
        build_model();
        base  = done_cnt;
        start = 1'b1;
        tick  = start_tick;
        @(posedge clock);
        #1;
        start = 1'b0;
        tick  = 1'b0;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(3, 6);
            repeat (gap - 1) @(posedge clock);
            #1;
            if (mid_start && i == 1) begin
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
            if (abort_at == i) begin
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
                check_eq({name, "_abort_key"}, key_address, 0);
                check_eq({name, "_abort_wren"}, wren, 1);
                check_eq({name, "_abort_busy"}, busy, 0);
                check_eq({name, "_abort_addr"}, rom_addr, 0);
                return;
            end
            ek = exp_q.pop_front();
            ea = exp_addr_q.pop_front();
            check_eq({name, "_key"}, key_address, ek);
            check_eq({name, "_addr"}, rom_addr, ea);
            check_eq({name, "_busy"}, busy, 1);
            check_eq({name, "_wren"}, wren, 0);
            check_eq({name, "_early_done"}, done_cnt - base, 0);
            tick = 1'b1;
            @(posedge clock);
            #1;
            tick = 1'b0;
        end
        k = 0;
        while (!song_done && k < 10) begin
            @(posedge clock);
            #1;
            k++;
        end
        check_eq({name, "_done_seen"}, song_done, 1);
        check_eq({name, "_done_lat"}, k, exp_marker ? 2 : 0);
        @(posedge clock);
        #1;
        check_eq({name, "_done_pulse"}, song_done, 0);
        check_eq({name, "_done_cnt"}, done_cnt - base, 1);
        check_eq({name, "_notes"}, note_count, exp_notes);
        check_eq({name, "_end_wren"}, wren, 0);
        check_eq({name, "_end_key"}, key_address, 0);
`ifdef LOOP_EN
        check_eq({name, "_loop_busy"}, busy, 1);
        do_reset();
`else
        check_eq({name, "_end_busy"}, busy, 0);
`endif
    endtask

    initial begin
        int n;
        int code;
        reset = 1'b0;
        start = 1'b0;
        tick  = 1'b0;
        clear_rom();
        do_reset();

        // single note, start coinciding with a tick
        clear_rom();
        put(0, 1, 10);
        run_song("one_note", -1, 0, 1);

        // restart from the finished state: note, rest, short note
        clear_rom();
        put(0, 2, 6);
        put(1, 0, 5);
        put(2, 3, 2);
        run_song("three_ent", -1, 0, 0);

        // zero-duration note and start while playing
        clear_rom();
        put(0, 1, 0);
        put(1, 2, 3);
        put(2, 0, 2);
        run_song("zero_dur", -1, 1, 0);

        // reset after two ticks of a note
        clear_rom();
        put(0, 3, 8);
        run_song("abort", 2, 0, 0);

        for (int r = 0; r < 6; r++) begin
            clear_rom();
            n = $urandom_range(1, 6);
            for (int e = 0; e < n; e++) begin
                code = $urandom_range(0, 3);
                put(e, code, (code == 0) ? $urandom_range(1, 7) : $urandom_range(0, 7));
            end
            run_song("rand", -1, (r % 2) == 1, 0);
        end

        // full chart with no end marker: song ends after the last address
        for (int e = 0; e < DEPTH; e++) begin
            code = $urandom_range(0, 3);
            put(e, code, (code == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2));
        end
        run_song("wrap", -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
